// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the MEM stage: memory op codes, exception codes, byte enables.
// No logic lives here; the LSU decode and the EX/MEM register both import it.
// Op codes are 4-bit so the EX stage can pass them through unchanged.
package cpu_mem_pkg;

  localparam int LSU_AW = 32;
  localparam int LSU_RW = 5;

  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LBU  = 4'd2;
  localparam logic [3:0] MEM_OP_LH   = 4'd3;
  localparam logic [3:0] MEM_OP_LHU  = 4'd4;
  localparam logic [3:0] MEM_OP_LW   = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  typedef enum logic {
    LSU_RUN      = 1'b0,
    LSU_EXC_WAIT = 1'b1
  } lsu_state_e;

  // Contents of the EX/MEM pipeline register.
  typedef struct packed {
    logic              valid;
    logic [LSU_AW-1:0] pc;
    logic [LSU_AW-1:0] addr;
    logic [LSU_AW-1:0] wdata;
    logic [3:0]        op;
    logic              reg_write;
    logic [LSU_RW-1:0] rd;
  } exmem_t;

endpackage

// File: rtl/lsu_be_decode.sv
// Decodes a memory op and the low address bits into DM byte enables, sign and alignment.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
module lsu_be_decode
  import cpu_mem_pkg::*;
(
  input  logic [3:0] op,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       sign,
  output logic       aligned,
  output logic       is_load,
  output logic       is_store
);

  // Lane selection by access size; a misaligned or non-memory op drives no lanes.
  always_comb begin
    be       = BE_NONE;
    aligned  = 1'b1;
    is_load  = op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
    is_store = op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
        case (addr_lo)
          2'd0:    be = BE_B0;
          2'd1:    be = BE_B1;
          2'd2:    be = BE_B2;
          default: be = BE_B3;
        endcase
      end
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
        aligned = ~addr_lo[0];
        be      = addr_lo[0] ? BE_NONE : (addr_lo[1] ? BE_H1 : BE_H0);
      end
      MEM_OP_LW, MEM_OP_SW: begin
        aligned = (addr_lo == 2'd0);
        be      = (addr_lo == 2'd0) ? BE_W : BE_NONE;
      end
      default: be = BE_NONE;
    endcase
    // Only signed byte/half loads ask DM to sign-extend, and only when they actually access.
    sign = aligned & ((op == MEM_OP_LB) | (op == MEM_OP_LH));
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// EX/MEM register plus DM load/store control with address-error exception handshake to CP0.
// Latency: one register stage; DM controls are decoded from it with no added cycle.
// Backpressure: stall_i holds the register; a pending exception bubbles it until exc_ack_i.
module mem_stage_lsu
  import cpu_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          ex_valid_i,
  input  logic [AW-1:0] ex_pc_i,
  input  logic [AW-1:0] ex_addr_i,
  input  logic [AW-1:0] ex_wdata_i,
  input  logic [3:0]    ex_mem_op_i,
  input  logic          ex_reg_write_i,
  input  logic [RW-1:0] ex_rd_i,
  input  logic          exc_ack_i,
  output logic [AW-1:0] dm_addr_o,
  output logic [AW-1:0] dm_wdata_o,
  output logic          dm_we_o,
  output logic [3:0]    dm_be_o,
  output logic          dm_sign_o,
  output logic          mem_valid_o,
  output logic [AW-1:0] mem_pc_o,
  output logic          mem_reg_write_o,
  output logic [RW-1:0] mem_rd_o,
  output logic          mem_is_load_o,
  output logic          exc_req_o,
  output logic [4:0]    exc_code_o,
  output logic [AW-1:0] exc_epc_o,
  output logic [AW-1:0] exc_badvaddr_o
);

  exmem_t     r;
  lsu_state_e state;
  logic       aligned, is_load, is_store, mis, run;

  lsu_be_decode u_dec (
    .op       (r.op),
    .addr_lo  (r.addr[1:0]),
    .be       (dm_be_o),
    .sign     (dm_sign_o),
    .aligned  (aligned),
    .is_load  (is_load),
    .is_store (is_store)
  );

  assign run = (state == LSU_RUN);
  assign mis = r.valid & (is_load | is_store) & ~aligned;

  assign dm_addr_o       = r.addr;
  assign dm_wdata_o      = r.wdata;
  assign dm_we_o         = r.valid & is_store & ~mis & run;
  assign mem_valid_o     = r.valid & ~mis & run;
  assign mem_reg_write_o = r.reg_write & ~mis & run;
  assign mem_is_load_o   = r.valid & is_load;
  assign mem_pc_o        = r.pc;
  assign mem_rd_o        = r.rd;

  // EX/MEM register: flush wins over stall; while an exception is pending, new work is bubbled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
    end else if (flush_i || (!stall_i && !run)) begin
      r.valid     <= 1'b0;
      r.op        <= MEM_OP_NONE;
      r.reg_write <= 1'b0;
    end else if (!stall_i) begin
      r <= '{valid: ex_valid_i, pc: ex_pc_i, addr: ex_addr_i, wdata: ex_wdata_i,
             op: ex_mem_op_i, reg_write: ex_reg_write_i, rd: ex_rd_i};
    end
  end

  // Exception FSM: a misaligned access captures its context and waits for CP0 to acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= LSU_RUN;
      exc_req_o      <= 1'b0;
      exc_code_o     <= EXC_NONE;
      exc_epc_o      <= '0;
      exc_badvaddr_o <= '0;
    end else begin
      case (state)
        LSU_RUN: begin
          // A stalled fault is only taken once the stall releases.
          if (mis && !stall_i) begin
            state          <= LSU_EXC_WAIT;
            exc_req_o      <= 1'b1;
            exc_code_o     <= is_load ? EXC_ADEL : EXC_ADES;
            exc_epc_o      <= r.pc;
            exc_badvaddr_o <= r.addr;
          end
        end
        LSU_EXC_WAIT: begin
          if (exc_ack_i) begin
            state      <= LSU_RUN;
            exc_req_o  <= 1'b0;
            exc_code_o <= EXC_NONE;
          end
        end
        default: state <= LSU_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios then randomized traffic.
// A behavioural model of the stage and a small byte-lane data memory supply expectations.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mem_stage_lsu;
  import cpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i, ex_valid_i, ex_reg_write_i, exc_ack_i;
  logic [31:0] ex_pc_i, ex_addr_i, ex_wdata_i;
  logic [3:0]  ex_mem_op_i;
  logic [4:0]  ex_rd_i;
  logic [31:0] dm_addr_o, dm_wdata_o, mem_pc_o, exc_epc_o, exc_badvaddr_o;
  logic        dm_we_o, dm_sign_o, mem_valid_o, mem_reg_write_o, mem_is_load_o, exc_req_o;
  logic [3:0]  dm_be_o;
  logic [4:0]  mem_rd_o, exc_code_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: the instruction sitting in MEM plus the pending-exception record.
  bit          m_valid, m_rw, m_exc;
  logic [31:0] m_pc, m_addr, m_wdata, m_epc, m_bad;
  logic [3:0]  m_op;
  logic [4:0]  m_rd, m_code;
  logic [31:0] dm [0:15];

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
    .ex_mem_op_i(ex_mem_op_i), .ex_reg_write_i(ex_reg_write_i), .ex_rd_i(ex_rd_i),
    .exc_ack_i(exc_ack_i),
    .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o), .dm_we_o(dm_we_o), .dm_be_o(dm_be_o),
    .dm_sign_o(dm_sign_o), .mem_valid_o(mem_valid_o), .mem_pc_o(mem_pc_o),
    .mem_reg_write_o(mem_reg_write_o), .mem_rd_o(mem_rd_o), .mem_is_load_o(mem_is_load_o),
    .exc_req_o(exc_req_o), .exc_code_o(exc_code_o), .exc_epc_o(exc_epc_o),
    .exc_badvaddr_o(exc_badvaddr_o)
  );

  function automatic int op_size(logic [3:0] op);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 1;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2;
      MEM_OP_LW, MEM_OP_SW:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit op_load(logic [3:0] op);
    return op == MEM_OP_LB || op == MEM_OP_LBU || op == MEM_OP_LH || op == MEM_OP_LHU || op == MEM_OP_LW;
  endfunction

  function automatic bit op_store(logic [3:0] op);
    return op == MEM_OP_SB || op == MEM_OP_SH || op == MEM_OP_SW;
  endfunction

  function automatic bit model_aligned();
    int sz = op_size(m_op);
    return sz != 0 && (int'(m_addr[1:0]) % sz) == 0;
  endfunction

  function automatic bit model_mis();
    return m_valid && op_size(m_op) != 0 && !model_aligned();
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_all();
    int       sz  = op_size(m_op);
    bit       al  = model_aligned();
    bit       mis = model_mis();
    logic [3:0] ebe = al ? 4'(((1 << sz) - 1) << m_addr[1:0]) : 4'b0000;
    chk("dm_addr",   dm_addr_o,       m_addr);
    chk("dm_wdata",  dm_wdata_o,      m_wdata);
    chk("dm_we",     32'(dm_we_o),    32'(m_valid && op_store(m_op) && !mis && !m_exc));
    chk("dm_be",     32'(dm_be_o),    32'(ebe));
    chk("dm_sign",   32'(dm_sign_o),  32'(al && (m_op == MEM_OP_LB || m_op == MEM_OP_LH)));
    chk("mem_valid", 32'(mem_valid_o), 32'(m_valid && !mis && !m_exc));
    chk("mem_pc",    mem_pc_o,        m_pc);
    chk("mem_rw",    32'(mem_reg_write_o), 32'(m_rw && !mis && !m_exc));
    chk("mem_rd",    32'(mem_rd_o),   32'(m_rd));
    chk("mem_ld",    32'(mem_is_load_o), 32'(m_valid && op_load(m_op)));
    chk("exc_req",   32'(exc_req_o),  32'(m_exc));
    chk("exc_code",  32'(exc_code_o), m_exc ? 32'(m_code) : 32'd0);
    chk("exc_epc",   exc_epc_o,       m_epc);
    chk("exc_bad",   exc_badvaddr_o,  m_bad);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_edge();
    bit          n_exc  = m_exc;
    logic [4:0]  n_code = m_code;
    logic [31:0] n_epc  = m_epc, n_bad = m_bad;
    if (!m_exc) begin
      if (model_mis() && !stall_i) begin
        n_exc = 1; n_code = op_load(m_op) ? 5'd4 : 5'd5; n_epc = m_pc; n_bad = m_addr;
      end
    end else if (exc_ack_i) begin
      n_exc = 0; n_code = 0;
    end
    if (flush_i || (!stall_i && m_exc)) begin
      m_valid = 0; m_op = MEM_OP_NONE; m_rw = 0;
    end else if (!stall_i) begin
      m_valid = ex_valid_i; m_pc = ex_pc_i; m_addr = ex_addr_i; m_wdata = ex_wdata_i;
      m_op = ex_mem_op_i; m_rw = ex_reg_write_i; m_rd = ex_rd_i;
    end
    m_exc = n_exc; m_code = n_code; m_epc = n_epc; m_bad = n_bad;
  endtask

  // Bench data memory: takes DUT's unshifted data and places it in the enabled lanes.
  task automatic dm_write();
    int idx = int'(dm_addr_o[5:2]);
    for (int k = 0; k < 4; k++) begin
      if (dm_be_o[k]) begin
        if (dm_be_o == 4'b1111)                          dm[idx][8*k +: 8] = dm_wdata_o[8*k +: 8];
        else if (dm_be_o == 4'b0011 || dm_be_o == 4'b1100) dm[idx][8*k +: 8] = dm_wdata_o[8*(k%2) +: 8];
        else                                             dm[idx][8*k +: 8] = dm_wdata_o[7:0];
      end
    end
  endtask

  function automatic logic [31:0] dm_read();
    logic [31:0] w = dm[int'(dm_addr_o[5:2])];
    case (dm_be_o)
      4'b1111: return w;
      4'b0011: return dm_sign_o ? {{16{w[15]}}, w[15:0]}  : {16'h0, w[15:0]};
      4'b1100: return dm_sign_o ? {{16{w[31]}}, w[31:16]} : {16'h0, w[31:16]};
      4'b0001: return dm_sign_o ? {{24{w[7]}},  w[7:0]}   : {24'h0, w[7:0]};
      4'b0010: return dm_sign_o ? {{24{w[15]}}, w[15:8]}  : {24'h0, w[15:8]};
      4'b0100: return dm_sign_o ? {{24{w[23]}}, w[23:16]} : {24'h0, w[23:16]};
      4'b1000: return dm_sign_o ? {{24{w[31]}}, w[31:24]} : {24'h0, w[31:24]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    model_edge();
    if (dm_we_o) dm_write();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_valid = 0; m_rw = 0; m_exc = 0; m_pc = 0; m_addr = 0; m_wdata = 0;
    m_epc = 0; m_bad = 0; m_op = MEM_OP_NONE; m_rd = 0; m_code = 0;
    check_all();
    #1;
    rst = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc, input logic rw, input logic [4:0] rd);
    ex_valid_i = (op != MEM_OP_NONE) || rw; ex_mem_op_i = op; ex_addr_i = addr;
    ex_wdata_i = wdata; ex_pc_i = pc; ex_reg_write_i = rw; ex_rd_i = rd;
  endtask

  task automatic idle();
    drive(MEM_OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dm[i] = 32'h0;
    stall_i = 0; flush_i = 0; exc_ack_i = 0; idle();
    do_reset();
    chk("reset_be", 32'(dm_be_o), 32'h0);
    tick();

    // Aligned halfword store to upper half of word 1.
    drive(MEM_OP_SH, 32'h6, 32'h0000BEEF, 32'h10, 1'b0, 5'd0); tick();
    chk("sh_be", 32'(dm_be_o), 32'hC); chk("sh_we", 32'(dm_we_o), 32'h1);
    idle(); tick();
    chk("sh_dm", 32'(dm[1][31:16]), 32'hBEEF);

    // Byte store then signed and unsigned byte loads of the same lane.
    drive(MEM_OP_SB, 32'h13, 32'h00000080, 32'h14, 1'b0, 5'd0); tick();
    drive(MEM_OP_LB, 32'h13, 32'h0, 32'h18, 1'b1, 5'd3); tick();
    chk("lb_be", 32'(dm_be_o), 32'h8); chk("lb_sign", 32'(dm_sign_o), 32'h1);
    chk("lb_data", dm_read(), 32'hFFFFFF80);
    drive(MEM_OP_LBU, 32'h13, 32'h0, 32'h1C, 1'b1, 5'd4); tick();
    chk("lbu_data", dm_read(), 32'h00000080);

    // Misaligned word load raises AdEL one cycle later.
    drive(MEM_OP_LW, 32'h2, 32'h0, 32'h40, 1'b1, 5'd5); tick();
    chk("lw_we", 32'(dm_we_o), 32'h0); chk("lw_rw", 32'(mem_reg_write_o), 32'h0);
    idle(); tick();
    chk("adel_req", 32'(exc_req_o), 32'h1); chk("adel_code", 32'(exc_code_o), 32'h4);
    chk("adel_epc", exc_epc_o, 32'h40); chk("adel_bad", exc_badvaddr_o, 32'h2);
    exc_ack_i = 1; tick(); exc_ack_i = 0;
    chk("adel_ack", 32'(exc_req_o), 32'h0);

    // Misaligned store followed by a good store: neither writes until after the ack.
    drive(MEM_OP_SW, 32'h1, 32'h11111111, 32'h50, 1'b0, 5'd0); tick();
    drive(MEM_OP_SW, 32'h8, 32'h22222222, 32'h54, 1'b0, 5'd0); tick();
    chk("ades_code", 32'(exc_code_o), 32'h5); chk("ades_we", 32'(dm_we_o), 32'h0);
    idle(); tick(); tick();
    chk("ades_dm", dm[2], 32'h0);
    exc_ack_i = 1; tick(); exc_ack_i = 0; tick();
    chk("ades_run", 32'(exc_req_o), 32'h0);

    // Stall holds an aligned store for two cycles; flush with stall bubbles it.
    drive(MEM_OP_SW, 32'h10, 32'hCAFEF00D, 32'h60, 1'b0, 5'd0); tick();
    stall_i = 1; drive(MEM_OP_LW, 32'h20, 32'h0, 32'h64, 1'b1, 5'd6);
    tick(); chk("stall_we1", 32'(dm_we_o), 32'h1); chk("stall_addr", dm_addr_o, 32'h10);
    tick(); chk("stall_we2", 32'(dm_we_o), 32'h1);
    flush_i = 1; tick(); chk("flush_we", 32'(dm_we_o), 32'h0);
    flush_i = 0; stall_i = 0;
    chk("sw_dm", dm[4], 32'hCAFEF00D);

    // Reset while waiting for CP0.
    drive(MEM_OP_SH, 32'h3, 32'h0, 32'h70, 1'b0, 5'd0); tick();
    idle(); tick();
    chk("pre_rst_req", 32'(exc_req_o), 32'h1);
    do_reset();
    chk("rst_req", 32'(exc_req_o), 32'h0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] op = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 7) == 0) op = MEM_OP_NONE;
      drive(op, $urandom & 32'h3F, $urandom, $urandom & 32'hFFFC, 1'($urandom), 5'($urandom));
      if (op == MEM_OP_NONE) begin ex_valid_i = 0; ex_reg_write_i = 0; end
      stall_i   = ($urandom_range(0, 5) == 0);
      flush_i   = ($urandom_range(0, 9) == 0);
      exc_ack_i = m_exc && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
